// File: rtl/ps2_pkg.sv
// Shared constants and state encoding for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam int         FRAME_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser and saturating-count deglitcher for the PS/2 clock line,
// producing a one-cycle strobe when the filtered level falls.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic fe
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    logic [1:0] sync_reg;
    logic [3:0] cnt_reg;
    logic       level_reg;
    logic       fe_reg;

    // Idle PS/2 lines sit high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b1;
            fe_reg    <= 1'b0;
        end else begin
            fe_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                level_reg <= sync_reg[1];
                cnt_reg   <= '0;
                fe_reg    <= level_reg;
            end else begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    assign fe = fe_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host deframer with F0/E0 prefix resolution, frame timeout and
// a held key-code bus with per-event strobe.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_BREAK,
    output logic       KEY_EXT,
    output logic       FRAME_ERR
);

    localparam logic [2:0]  LAST_BIT = 3'(FRAME_BITS - 1);
    localparam logic [15:0] TO_MAX   = 16'(TIMEOUT_CYCLES - 1);

    ps2_state_t  state_reg, state_next;
    logic        fe;
    logic [1:0]  data_sync_reg;
    logic        data_bit;
    logic [7:0]  shreg_reg;
    logic [2:0]  bit_cnt_reg;
    logic        parity_reg;
    logic [15:0] to_cnt_reg;
    logic        timeout;
    logic        byte_done;
    logic        frame_err_next;
    logic        break_pend_reg;
    logic        ext_pend_reg;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk   (CLK_50M),
        .rst_n (RST_N),
        .raw   (PS2_CLK),
        .fe    (fe)
    );

    // Data is only sampled on a filtered clock edge, so it needs no deglitching.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            data_sync_reg <= 2'b11;
        end else begin
            data_sync_reg <= {data_sync_reg[0], PS2_DATA};
        end
    end
    assign data_bit = data_sync_reg[1];

    // A coinciding clock edge beats the timeout.
    assign timeout = (state_reg != IDLE) && !fe && (to_cnt_reg == TO_MAX);

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (timeout) begin
            state_next = IDLE;
        end else if (fe) begin
            case (state_reg)
                IDLE:    if (!data_bit) state_next = DATA;
                DATA:    if (bit_cnt_reg == LAST_BIT) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        byte_done      = 1'b0;
        frame_err_next = timeout;
        if (fe && state_reg == STOP) begin
            if (data_bit && odd_parity_ok(shreg_reg, parity_reg)) begin
                byte_done = 1'b1;
            end else begin
                frame_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            parity_reg  <= 1'b0;
        end else if (fe) begin
            case (state_reg)
                IDLE: bit_cnt_reg <= '0;
                DATA: begin
                    shreg_reg   <= {data_bit, shreg_reg[7:1]};
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
                PARITY:  parity_reg <= data_bit;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            to_cnt_reg <= '0;
        end else if (fe || state_reg == IDLE) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            KEY_CODE       <= 8'h00;
            KEY_VALID      <= 1'b0;
            KEY_BREAK      <= 1'b0;
            KEY_EXT        <= 1'b0;
            FRAME_ERR      <= 1'b0;
            break_pend_reg <= 1'b0;
            ext_pend_reg   <= 1'b0;
        end else begin
            KEY_VALID <= 1'b0;
            FRAME_ERR <= frame_err_next;
            if (frame_err_next) begin
                break_pend_reg <= 1'b0;
                ext_pend_reg   <= 1'b0;
            end else if (byte_done) begin
                if (shreg_reg == PS2_BREAK) begin
                    break_pend_reg <= 1'b1;
                end else if (shreg_reg == PS2_EXT) begin
                    ext_pend_reg <= 1'b1;
                end else begin
                    KEY_VALID      <= 1'b1;
                    KEY_BREAK      <= break_pend_reg;
                    KEY_EXT        <= ext_pend_reg;
                    // A release reports the event but leaves the held make code alone.
                    if (!break_pend_reg) KEY_CODE <= shreg_reg;
                    break_pend_reg <= 1'b0;
                    ext_pend_reg   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of frames with expected held
// outputs, plus sequences for latency, glitch, timeout and mid-frame reset.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 600;
    localparam int HALF       = 50;
    localparam int NVEC       = 17;

    logic       CLK_50M;
    logic       RST_N;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [7:0] KEY_CODE;
    logic       KEY_VALID;
    logic       KEY_BREAK;
    logic       KEY_EXT;
    logic       FRAME_ERR;

    ps2_key_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK_50M  (CLK_50M),
        .RST_N    (RST_N),
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA),
        .KEY_CODE (KEY_CODE),
        .KEY_VALID(KEY_VALID),
        .KEY_BREAK(KEY_BREAK),
        .KEY_EXT  (KEY_EXT),
        .FRAME_ERR(FRAME_ERR)
    );

    initial CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_code;
        logic       exp_brk;
        logic       exp_ext;
    } vec_t;

    vec_t vecs[NVEC];

    int passed = 0;
    int total  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;

    always @(negedge CLK_50M) begin
        if (KEY_VALID) valid_cnt++;
        if (FRAME_ERR) err_cnt++;
        if (KEY_VALID && FRAME_ERR) both_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLK_50M);
        #1;
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        err_cnt   = 0;
    endtask

    // Sends the first nbits of a frame; glitch_bit >= 0 adds a 3-cycle low pulse
    // during the high phase before that bit's falling edge.
    task automatic send_bits(input logic [7:0] b, input logic bad_par,
                             input int nbits, input int glitch_bit);
        logic [10:0] f;
        logic        p;
        p = bad_par ? (^b) : ~(^b);
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = f[i];
            if (i == glitch_bit) begin
                wait_clk(20);
                PS2_CLK = 1'b0;
                wait_clk(3);
                PS2_CLK = 1'b1;
                wait_clk(HALF - 23);
            end else begin
                wait_clk(HALF);
            end
            PS2_CLK = 1'b0;
            wait_clk(HALF);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bits(b, bad_par, 11, -1);
        wait_clk(150);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0]  = '{8'h69, 1'b0, 1, 0, 8'h69, 1'b0, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 0, 0, 8'h69, 1'b0, 1'b0};
        vecs[2]  = '{8'h69, 1'b0, 1, 0, 8'h69, 1'b1, 1'b0};
        vecs[3]  = '{8'hE0, 1'b0, 0, 0, 8'h69, 1'b1, 1'b0};
        vecs[4]  = '{8'h75, 1'b0, 1, 0, 8'h75, 1'b0, 1'b1};
        vecs[5]  = '{8'h72, 1'b0, 1, 0, 8'h72, 1'b0, 1'b0};
        vecs[6]  = '{8'h7A, 1'b1, 0, 1, 8'h72, 1'b0, 1'b0};
        vecs[7]  = '{8'hF0, 1'b0, 0, 0, 8'h72, 1'b0, 1'b0};
        vecs[8]  = '{8'h7A, 1'b1, 0, 1, 8'h72, 1'b0, 1'b0};
        vecs[9]  = '{8'h73, 1'b0, 1, 0, 8'h73, 1'b0, 1'b0};
        vecs[10] = '{8'h7A, 1'b1, 0, 1, 8'h73, 1'b0, 1'b0};
        vecs[11] = '{8'hF0, 1'b0, 0, 0, 8'h73, 1'b0, 1'b0};
        vecs[12] = '{8'h73, 1'b0, 1, 0, 8'h73, 1'b1, 1'b0};
        vecs[13] = '{8'h73, 1'b0, 1, 0, 8'h73, 1'b0, 1'b0};
        vecs[14] = '{8'hE0, 1'b0, 0, 0, 8'h73, 1'b0, 1'b0};
        vecs[15] = '{8'hF0, 1'b0, 0, 0, 8'h73, 1'b0, 1'b0};
        vecs[16] = '{8'h75, 1'b0, 1, 0, 8'h73, 1'b1, 1'b1};

        RST_N    = 1'b0;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        wait_clk(5);
        check("reset_code",  KEY_CODE,  8'h00);
        check("reset_valid", KEY_VALID, 0);
        check("reset_break", KEY_BREAK, 0);
        check("reset_ext",   KEY_EXT,   0);
        check("reset_err",   FRAME_ERR, 0);
        RST_N = 1'b1;
        wait_clk(20);
        check("idle_no_strobe", valid_cnt + err_cnt, 0);

        for (int v = 0; v < NVEC; v++) begin
            clear_counts();
            send_frame(vecs[v].data, vecs[v].bad_par);
            $display("vec %0d: byte %02h bad_par=%0d -> valid=%0d err=%0d code=%02h brk=%0d ext=%0d",
                     v, vecs[v].data, vecs[v].bad_par, valid_cnt, err_cnt, KEY_CODE, KEY_BREAK, KEY_EXT);
            check($sformatf("vec%0d_valid", v), valid_cnt, vecs[v].exp_valid);
            check($sformatf("vec%0d_err", v),   err_cnt,   vecs[v].exp_err);
            check($sformatf("vec%0d_code", v),  KEY_CODE,  vecs[v].exp_code);
            check($sformatf("vec%0d_brk", v),   KEY_BREAK, vecs[v].exp_brk);
            check($sformatf("vec%0d_ext", v),   KEY_EXT,   vecs[v].exp_ext);
        end

        // Latency from the raw stop-bit falling edge to KEY_VALID.
        clear_counts();
        send_bits(8'h1C, 1'b0, 10, -1);
        PS2_DATA = 1'b1;
        wait_clk(HALF);
        PS2_CLK = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge CLK_50M);
            #1;
            if (KEY_VALID) lat = k;
        end
        wait_clk(1);
        check("latency_pulse_width", KEY_VALID, 0);
        wait_clk(HALF);
        PS2_CLK = 1'b1;
        wait_clk(100);
        $display("latency: KEY_VALID %0d cycles after raw edge, code=%02h", lat, KEY_CODE);
        check("latency_cycles", lat, FILTER_LEN + 3);
        check("latency_code", KEY_CODE, 8'h1C);
        check("latency_valid_once", valid_cnt, 1);

        // Short low glitch mid-frame must not shift in an extra bit.
        clear_counts();
        send_bits(8'h74, 1'b0, 11, 5);
        wait_clk(150);
        $display("glitch: valid=%0d err=%0d code=%02h", valid_cnt, err_cnt, KEY_CODE);
        check("glitch_valid", valid_cnt, 1);
        check("glitch_err",   err_cnt,   0);
        check("glitch_code",  KEY_CODE,  8'h74);

        // F0 then a stalled frame: the timeout must also drop the break prefix.
        send_frame(8'hF0, 1'b0);
        clear_counts();
        send_bits(8'h44, 1'b0, 5, -1);
        wait_clk(TIMEOUT + 200);
        $display("timeout: valid=%0d err=%0d", valid_cnt, err_cnt);
        check("timeout_err",   err_cnt,   1);
        check("timeout_valid", valid_cnt, 0);
        clear_counts();
        send_frame(8'h6C, 1'b0);
        $display("after timeout: valid=%0d code=%02h brk=%0d", valid_cnt, KEY_CODE, KEY_BREAK);
        check("post_timeout_valid", valid_cnt, 1);
        check("post_timeout_code",  KEY_CODE,  8'h6C);
        check("post_timeout_brk",   KEY_BREAK, 0);
        check("post_timeout_err",   err_cnt,   0);

        // Reset in the middle of a frame.
        clear_counts();
        send_bits(8'h33, 1'b0, 6, -1);
        RST_N = 1'b0;
        wait_clk(5);
        check("midrst_code",  KEY_CODE,  8'h00);
        check("midrst_break", KEY_BREAK, 0);
        check("midrst_ext",   KEY_EXT,   0);
        RST_N = 1'b1;
        wait_clk(TIMEOUT + 200);
        $display("mid-frame reset: valid=%0d err=%0d code=%02h", valid_cnt, err_cnt, KEY_CODE);
        check("midrst_no_valid", valid_cnt, 0);
        check("midrst_no_err",   err_cnt,   0);
        clear_counts();
        send_frame(8'h29, 1'b0);
        $display("after reset: valid=%0d code=%02h", valid_cnt, KEY_CODE);
        check("post_rst_valid", valid_cnt, 1);
        check("post_rst_code",  KEY_CODE,  8'h29);

        check("strobe_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
